// File: rtl/aes_result_checker.sv
// ---------------------------------------------------------------------------
// aes_result_checker
//
// Purpose:
//   Sits downstream of an AES encoder/decoder pair. Each vector applied to
//   the cores is captured with its expected results and delayed through a
//   shift line that matches the core latency. When the delayed copy reaches
//   the last stage, the live core outputs are compared against it. The result
//   is reported one cycle later, and running pass/fail statistics are kept.
//
// Parameters:
//   LATENCY    : cycles from core inputs to core outputs (>= 1)
//   STATE_BITS : AES state width
//   CNT_WIDTH  : width of sequence / pass / fail counters
//
// Ports:
//   clock       : system clock, rising edge
//   reset       : asynchronous active-low reset
//   clear       : synchronous flush of the delay line and statistics
//   in_valid    : a vector is applied to the cores this cycle
//   in_plain    : plaintext to the encoder (expected decoder output)
//   in_encrypt  : ciphertext to the decoder (expected encoder output)
//   enc_out     : encoder output
//   dec_out     : decoder output
//   chk_valid   : one-cycle pulse, a result is reported
//   chk_enc_ok  : encoder result matched
//   chk_dec_ok  : decoder result matched
//   chk_seq     : sequence number of the reported vector
//   pass_count  : vectors with both checks OK (saturating)
//   fail_count  : vectors with any check failing (saturating)
//   in_flight   : number of valid vectors in the delay line
//   error       : sticky, set on the first failing vector
//
// Optional feature (macro AES_CHECK_CAPTURE_EN):
//   Adds first_fail_seq / first_fail_exp / first_fail_act / first_fail_valid,
//   which capture the details of the failure that first sets error.
// ---------------------------------------------------------------------------
module aes_result_checker #(
  parameter int LATENCY    = 10,
  parameter int STATE_BITS = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             in_valid,
  input  logic [STATE_BITS-1:0]            in_plain,
  input  logic [STATE_BITS-1:0]            in_encrypt,
  input  logic [STATE_BITS-1:0]            enc_out,
  input  logic [STATE_BITS-1:0]            dec_out,
  output logic                             chk_valid,
  output logic                             chk_enc_ok,
  output logic                             chk_dec_ok,
  output logic [CNT_WIDTH-1:0]             chk_seq,
  output logic [CNT_WIDTH-1:0]             pass_count,
  output logic [CNT_WIDTH-1:0]             fail_count,
  output logic [$clog2(LATENCY+1)-1:0]     in_flight,
`ifdef AES_CHECK_CAPTURE_EN
  output logic [CNT_WIDTH-1:0]             first_fail_seq,
  output logic [2*STATE_BITS-1:0]          first_fail_exp,
  output logic [2*STATE_BITS-1:0]          first_fail_act,
  output logic                             first_fail_valid,
`endif
  output logic                             error
);

  localparam int FlW = $clog2(LATENCY + 1);

  // Delay line: valid bits are reset, payload is not.
  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [STATE_BITS-1:0] expEnc_q [LATENCY];
  logic [STATE_BITS-1:0] expDec_q [LATENCY];
  logic [CNT_WIDTH-1:0]  stSeq_q  [LATENCY];

  logic [CNT_WIDTH-1:0] seq_q, seq_d;
  logic                 chkValid_q, chkValid_d;
  logic                 chkEncOk_q, chkEncOk_d;
  logic                 chkDecOk_q, chkDecOk_d;
  logic [CNT_WIDTH-1:0] chkSeq_q, chkSeq_d;
  logic [CNT_WIDTH-1:0] pass_q, pass_d;
  logic [CNT_WIDTH-1:0] fail_q, fail_d;
  logic                 error_q, error_d;
  logic [FlW-1:0]       inFlight_q, inFlight_d;

  logic cmpValid;
  logic encMatch;
  logic decMatch;

  // The last stage holds the vector whose results are on the core outputs now.
  assign cmpValid = vld_q[LATENCY-1];
  assign encMatch = (enc_out == expEnc_q[LATENCY-1]);
  assign decMatch = (dec_out == expDec_q[LATENCY-1]);

  // Payload shift; it always moves, and the valid bits decide what counts.
  always_ff @(posedge clock) begin
    expEnc_q[0] <= in_encrypt;
    expDec_q[0] <= in_plain;
    stSeq_q[0]  <= seq_q;
    for (int k = 1; k < LATENCY; k++) begin
      expEnc_q[k] <= expEnc_q[k-1];
      expDec_q[k] <= expDec_q[k-1];
      stSeq_q[k]  <= stSeq_q[k-1];
    end
  end

  // Next-state logic for the valid line, the result registers and statistics.
  // The match signals are only consulted under cmpValid, so X on the core
  // outputs during bubbles never reaches any register.
  always_comb begin
    vld_d      = '0;
    seq_d      = seq_q;
    chkValid_d = 1'b0;
    chkEncOk_d = 1'b0;
    chkDecOk_d = 1'b0;
    chkSeq_d   = chkSeq_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    error_d    = error_q;
    inFlight_d = inFlight_q;

    if (clear) begin
      seq_d      = '0;
      chkSeq_d   = '0;
      pass_d     = '0;
      fail_d     = '0;
      error_d    = 1'b0;
      inFlight_d = '0;
    end else begin
      vld_d[0] = in_valid;
      for (int k = 1; k < LATENCY; k++) begin
        vld_d[k] = vld_q[k-1];
      end
      if (in_valid) begin
        seq_d = seq_q + CNT_WIDTH'(1);
      end
      inFlight_d = inFlight_q + FlW'(in_valid) - FlW'(cmpValid);
      if (cmpValid) begin
        chkValid_d = 1'b1;
        chkEncOk_d = encMatch;
        chkDecOk_d = decMatch;
        chkSeq_d   = stSeq_q[LATENCY-1];
        if (encMatch && decMatch) begin
          if (pass_q != '1) pass_d = pass_q + CNT_WIDTH'(1);
        end else begin
          if (fail_q != '1) fail_d = fail_q + CNT_WIDTH'(1);
          error_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q      <= '0;
      seq_q      <= '0;
      chkValid_q <= 1'b0;
      chkEncOk_q <= 1'b0;
      chkDecOk_q <= 1'b0;
      chkSeq_q   <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      error_q    <= 1'b0;
      inFlight_q <= '0;
    end else begin
      vld_q      <= vld_d;
      seq_q      <= seq_d;
      chkValid_q <= chkValid_d;
      chkEncOk_q <= chkEncOk_d;
      chkDecOk_q <= chkDecOk_d;
      chkSeq_q   <= chkSeq_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      error_q    <= error_d;
      inFlight_q <= inFlight_d;
    end
  end

  assign chk_valid  = chkValid_q;
  assign chk_enc_ok = chkEncOk_q;
  assign chk_dec_ok = chkDecOk_q;
  assign chk_seq    = chkSeq_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign in_flight  = inFlight_q;
  assign error      = error_q;

`ifdef AES_CHECK_CAPTURE_EN
  logic [CNT_WIDTH-1:0]    ffSeq_q, ffSeq_d;
  logic [2*STATE_BITS-1:0] ffExp_q, ffExp_d;
  logic [2*STATE_BITS-1:0] ffAct_q, ffAct_d;
  logic                    ffValid_q, ffValid_d;

  // Capture only on the failing compare that raises error; later fails keep
  // the first snapshot.
  always_comb begin
    ffSeq_d   = ffSeq_q;
    ffExp_d   = ffExp_q;
    ffAct_d   = ffAct_q;
    ffValid_d = ffValid_q;
    if (clear) begin
      ffSeq_d   = '0;
      ffExp_d   = '0;
      ffAct_d   = '0;
      ffValid_d = 1'b0;
    end else if (cmpValid && !(encMatch && decMatch) && !error_q) begin
      ffSeq_d   = stSeq_q[LATENCY-1];
      ffExp_d   = {expEnc_q[LATENCY-1], expDec_q[LATENCY-1]};
      ffAct_d   = {enc_out, dec_out};
      ffValid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ffSeq_q   <= '0;
      ffExp_q   <= '0;
      ffAct_q   <= '0;
      ffValid_q <= 1'b0;
    end else begin
      ffSeq_q   <= ffSeq_d;
      ffExp_q   <= ffExp_d;
      ffAct_q   <= ffAct_d;
      ffValid_q <= ffValid_d;
    end
  end

  assign first_fail_seq   = ffSeq_q;
  assign first_fail_exp   = ffExp_q;
  assign first_fail_act   = ffAct_q;
  assign first_fail_valid = ffValid_q;
`endif

endmodule

// File: tb/tb_aes_result_checker.sv
// ---------------------------------------------------------------------------
// tb_aes_result_checker
//
// Drives vectors into two checker instances that share all inputs: the main
// 32-bit counter build and a 4-bit counter build used for the saturation and
// wrap scenario. The bench models the AES cores as a LATENCY-deep pipeline
// that returns the supplied ciphertext/plaintext, with an optional one-bit
// corruption on the encoder side. Expected results go into a scoreboard
// queue when a vector is issued and are popped when chk_valid appears.
// ---------------------------------------------------------------------------
module tb_aes_result_checker;

  localparam int L  = 10;
  localparam int SB = 128;
  localparam int CW = 32;
  localparam int SW = 4;
  localparam int FW = $clog2(L + 1);

  logic          clock    = 1'b0;
  logic          reset    = 1'b0;
  logic          clear    = 1'b0;
  logic          in_valid = 1'b0;
  logic [SB-1:0] in_plain   = '0;
  logic [SB-1:0] in_encrypt = '0;
  logic [SB-1:0] enc_out;
  logic [SB-1:0] dec_out;
  logic          injectFault = 1'b0;

  logic          chk_valid, chk_enc_ok, chk_dec_ok, error;
  logic [CW-1:0] chk_seq, pass_count, fail_count;
  logic [FW-1:0] in_flight;

  logic          sChkValid, sChkEncOk, sChkDecOk, sError;
  logic [SW-1:0] sChkSeq, sPass, sFail;
  logic [FW-1:0] sInFlight;

`ifdef AES_CHECK_CAPTURE_EN
  logic [CW-1:0]   ffSeq;
  logic [2*SB-1:0] ffExp, ffAct;
  logic            ffValid;
  logic [SW-1:0]   sFfSeq;
  logic [2*SB-1:0] sFfExp, sFfAct;
  logic            sFfValid;
`endif

  aes_result_checker #(.LATENCY(L), .STATE_BITS(SB), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_plain(in_plain), .in_encrypt(in_encrypt),
    .enc_out(enc_out), .dec_out(dec_out),
    .chk_valid(chk_valid), .chk_enc_ok(chk_enc_ok), .chk_dec_ok(chk_dec_ok),
    .chk_seq(chk_seq), .pass_count(pass_count), .fail_count(fail_count),
    .in_flight(in_flight),
`ifdef AES_CHECK_CAPTURE_EN
    .first_fail_seq(ffSeq), .first_fail_exp(ffExp),
    .first_fail_act(ffAct), .first_fail_valid(ffValid),
`endif
    .error(error)
  );

  aes_result_checker #(.LATENCY(L), .STATE_BITS(SB), .CNT_WIDTH(SW)) dutSmall (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_plain(in_plain), .in_encrypt(in_encrypt),
    .enc_out(enc_out), .dec_out(dec_out),
    .chk_valid(sChkValid), .chk_enc_ok(sChkEncOk), .chk_dec_ok(sChkDecOk),
    .chk_seq(sChkSeq), .pass_count(sPass), .fail_count(sFail),
    .in_flight(sInFlight),
`ifdef AES_CHECK_CAPTURE_EN
    .first_fail_seq(sFfSeq), .first_fail_exp(sFfExp),
    .first_fail_act(sFfAct), .first_fail_valid(sFfValid),
`endif
    .error(sError)
  );

  always #5 clock = ~clock;

  // Model of the AES cores: a fixed-latency pipe returning the supplied
  // results, driving X whenever no vector is emerging.
  logic [L-1:0]  corePipeV = '0;
  logic [L-1:0]  corePipeF = '0;
  logic [SB-1:0] corePipeEnc [L];
  logic [SB-1:0] corePipeDec [L];

  always @(posedge clock) begin
    corePipeV      <= {corePipeV[L-2:0], in_valid};
    corePipeF      <= {corePipeF[L-2:0], injectFault};
    corePipeEnc[0] <= in_encrypt;
    corePipeDec[0] <= in_plain;
    for (int k = 1; k < L; k++) begin
      corePipeEnc[k] <= corePipeEnc[k-1];
      corePipeDec[k] <= corePipeDec[k-1];
    end
  end

  assign enc_out = corePipeV[L-1] ? (corePipeEnc[L-1] ^ {{(SB-1){1'b0}}, corePipeF[L-1]}) : 'x;
  assign dec_out = corePipeV[L-1] ? corePipeDec[L-1] : 'x;

  typedef struct {
    logic [CW-1:0] seq;
    logic          encOk;
    logic          decOk;
    int            cycle;
  } sbItem_t;

  sbItem_t       sbQ[$];
  sbItem_t       item;
  int            compCount  = 0;
  int            errCount   = 0;
  int            cycleCnt   = 0;
  int            gotCount   = 0;
  int            peakFlight = 0;
  int            smallExp   = 0;
  bit            smallChk   = 1'b0;
  logic [CW-1:0] benchSeq   = '0;

  always @(posedge clock) cycleCnt++;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result monitor: pops the scoreboard for every reported result and checks
  // sequence, verdicts and the in_valid-to-chk_valid latency.
  always @(negedge clock) begin
    if (reset) begin
      if (int'(in_flight) > peakFlight) peakFlight = int'(in_flight);
      if (chk_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_result", 256'(sbQ.size()), 256'd1);
        end else begin
          item = sbQ.pop_front();
          checkOutput("chk_seq", 256'(chk_seq), 256'(item.seq));
          checkOutput("chk_enc_ok", 256'(chk_enc_ok), 256'(item.encOk));
          checkOutput("chk_dec_ok", 256'(chk_dec_ok), 256'(item.decOk));
          checkOutput("latency", 256'(cycleCnt - item.cycle), 256'(L + 1));
          gotCount++;
        end
      end
      if (smallChk && sChkValid) begin
        checkOutput("small_chk_seq", 256'(sChkSeq), 256'(smallExp % 16));
        smallExp++;
      end
    end
  end

  task automatic applyStimulus(input logic [SB-1:0] p, input logic [SB-1:0] e, input bit fault);
    @(negedge clock);
    in_valid    = 1'b1;
    in_plain    = p;
    in_encrypt  = e;
    injectFault = fault;
    sbQ.push_back('{seq: benchSeq, encOk: !fault, decOk: 1'b1, cycle: cycleCnt});
    benchSeq++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid    = 1'b0;
      injectFault = 1'b0;
    end
  endtask

  function automatic logic [SB-1:0] randState();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic issueRandom(input bit fault);
    applyStimulus(randState(), randState(), fault);
  endtask

  // Clear for one cycle; optionally with a vector that must be discarded.
  task automatic doClear(input bit withValid);
    @(negedge clock);
    clear       = 1'b1;
    in_valid    = withValid;
    in_plain    = randState();
    in_encrypt  = randState();
    injectFault = 1'b0;
    sbQ.delete();
    benchSeq = '0;
    @(negedge clock);
    clear    = 1'b0;
    in_valid = 1'b0;
  endtask

  logic [SB-1:0] p3, e3, pv, ev;

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("rst_chk_valid", 256'(chk_valid), 256'd0);
    checkOutput("rst_chk_seq", 256'(chk_seq), 256'd0);
    checkOutput("rst_pass", 256'(pass_count), 256'd0);
    checkOutput("rst_fail", 256'(fail_count), 256'd0);
    checkOutput("rst_in_flight", 256'(in_flight), 256'd0);
    checkOutput("rst_error", 256'(error), 256'd0);
    reset = 1'b1;
    idle(2);

    // FIPS-197 AES-128 vector (key 000102..0f); the checker sees only the
    // plaintext/ciphertext pair.
    applyStimulus(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);
    idle(L + 4);
    checkOutput("fips_got", 256'(gotCount), 256'd1);
    checkOutput("fips_pass", 256'(pass_count), 256'd1);
    checkOutput("fips_fail", 256'(fail_count), 256'd0);
    checkOutput("fips_error", 256'(error), 256'd0);

    // 50 back-to-back, then 20 with random gaps
    doClear(1'b0);
    gotCount   = 0;
    peakFlight = 0;
    repeat (50) issueRandom(1'b0);
    repeat (20) begin
      issueRandom(1'b0);
      idle($urandom_range(1, 3));
    end
    idle(L + 4);
    checkOutput("stream_got", 256'(gotCount), 256'd70);
    checkOutput("stream_pass", 256'(pass_count), 256'd70);
    checkOutput("stream_fail", 256'(fail_count), 256'd0);
    checkOutput("stream_peak", 256'(peakFlight), 256'(L));
    checkOutput("stream_in_flight", 256'(in_flight), 256'd0);

    // Encoder bit 0 corrupted on seq 3 only
    doClear(1'b0);
    p3 = '0;
    e3 = '0;
    for (int i = 0; i < 6; i++) begin
      pv = randState();
      ev = randState();
      if (i == 3) begin
        p3 = pv;
        e3 = ev;
      end
      applyStimulus(pv, ev, i == 3);
    end
    idle(L + 4);
    checkOutput("fault_fail", 256'(fail_count), 256'd1);
    checkOutput("fault_pass", 256'(pass_count), 256'd5);
    checkOutput("fault_error", 256'(error), 256'd1);
`ifdef AES_CHECK_CAPTURE_EN
    checkOutput("ff_valid", 256'(ffValid), 256'd1);
    checkOutput("ff_seq", 256'(ffSeq), 256'd3);
    checkOutput("ff_exp", ffExp, {e3, p3});
    checkOutput("ff_act", ffAct, {e3 ^ 128'd1, p3});
`endif
    repeat (3) issueRandom(1'b0);
    idle(L + 4);
    checkOutput("sticky_error", 256'(error), 256'd1);
    checkOutput("sticky_fail", 256'(fail_count), 256'd1);
    checkOutput("sticky_pass", 256'(pass_count), 256'd8);

    // clear with 5 vectors in flight and in_valid high in the same cycle
    repeat (5) issueRandom(1'b0);
    doClear(1'b1);
    checkOutput("clr_pass", 256'(pass_count), 256'd0);
    checkOutput("clr_fail", 256'(fail_count), 256'd0);
    checkOutput("clr_error", 256'(error), 256'd0);
    checkOutput("clr_in_flight", 256'(in_flight), 256'd0);
    checkOutput("clr_chk_valid", 256'(chk_valid), 256'd0);
`ifdef AES_CHECK_CAPTURE_EN
    checkOutput("clr_ff_valid", 256'(ffValid), 256'd0);
`endif
    idle(L + 4);
    checkOutput("clr_quiet_pass", 256'(pass_count), 256'd0);
    checkOutput("clr_quiet_in_flight", 256'(in_flight), 256'd0);
    issueRandom(1'b0);
    idle(L + 4);
    checkOutput("clr_next_pass", 256'(pass_count), 256'd1);

    // Reset pulse mid-stream
    repeat (4) issueRandom(1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_rst_chk_valid", 256'(chk_valid), 256'd0);
    checkOutput("mid_rst_pass", 256'(pass_count), 256'd0);
    checkOutput("mid_rst_fail", 256'(fail_count), 256'd0);
    checkOutput("mid_rst_in_flight", 256'(in_flight), 256'd0);
    checkOutput("mid_rst_error", 256'(error), 256'd0);
    checkOutput("mid_rst_chk_seq", 256'(chk_seq), 256'd0);
    sbQ.delete();
    benchSeq = '0;
    @(negedge clock);
    reset = 1'b1;
    idle(L + 4);
    checkOutput("post_rst_quiet_pass", 256'(pass_count), 256'd0);
    issueRandom(1'b0);
    idle(L + 4);
    checkOutput("post_rst_pass", 256'(pass_count), 256'd1);
    checkOutput("post_rst_in_flight", 256'(in_flight), 256'd0);

    // 4-bit counter build: saturation and sequence wrap
    doClear(1'b0);
    smallExp = 0;
    smallChk = 1'b1;
    repeat (20) issueRandom(1'b0);
    idle(L + 4);
    smallChk = 1'b0;
    checkOutput("small_results", 256'(smallExp), 256'd20);
    checkOutput("small_pass_sat", 256'(sPass), 256'd15);
    checkOutput("small_fail", 256'(sFail), 256'd0);
    checkOutput("main_pass_20", 256'(pass_count), 256'd20);

    checkOutput("sb_leftover", 256'(sbQ.size()), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
